sub_bytes_seq: RTL and testbench

Sequential, parametrised AES SubBytes / InvSubBytes engine for the iterative AES datapath. It accepts a 128-bit state over a valid/ready handshake and substitutes LANES bytes per clock through LANES shared S-box lanes. It returns the 128-bit result over a second valid/ready handshake. Designers trade area against latency via LANES; the inverse S-box is optional and selected per block for the decrypt path.

---
 rtl/sub_bytes_seq.sv | 160 ++++++++++++++++
 tb/tb_sub_bytes_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_seq.sv
// Iterative AES SubBytes / InvSubBytes engine: LANES S-box lanes process a
// 128-bit state over 16/LANES clocks between two valid/ready handshakes.
module sub_bytes_seq #(
  parameter int unsigned LANES  = 4,
  parameter bit          INV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned BEATS = 16 / LANES;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LW    = LANES * 8;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [127:0]    src_q;
  logic [127:0]    out_q;
  logic [CW-1:0]   cnt_q;
  logic            mode_q;
  logic            valid_q;
  logic            accept;
  logic            beat_en;
  logic            last_beat;
  logic            release_out;
  logic [LW-1:0]   lane_in;
  logic [LW-1:0]   lane_out;

  // GF(2^8) arithmetic over the AES polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (0 maps to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  assign lane_in = src_q[LW*32'(cnt_q) +: LW];

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    logic [7:0] fwd;
    assign fwd = sbox_fwd(lane_in[8*g +: 8]);
    if (INV_EN) begin : g_inv
      logic [7:0] inv;
      assign inv = sbox_inv(lane_in[8*g +: 8]);
      assign lane_out[8*g +: 8] = mode_q ? inv : fwd;
    end else begin : g_fwd
      assign lane_out[8*g +: 8] = fwd;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and datapath strobes
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    beat_en     = 1'b0;
    release_out = 1'b0;
    last_beat   = (cnt_q == CW'(BEATS - 1));
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        beat_en = 1'b1;
        if (last_beat) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          release_out = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Source latch, per-beat result write and output valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (accept) begin
        src_q  <= in_data;
        mode_q <= in_inv & INV_EN;
        cnt_q  <= '0;
      end
      if (beat_en) begin
        out_q[LW*32'(cnt_q) +: LW] <= lane_out;
        cnt_q                      <= cnt_q + CW'(1);
      end
      if (beat_en && last_beat) valid_q <= 1'b1;
      else if (release_out)     valid_q <= 1'b0;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = valid_q;
  assign out_data  = out_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: six instances (LANES 1..16, plus forward-only)
// share stimulus and are checked every cycle against a table-based model.
module tb_sub_bytes_seq;

  localparam int NI = 6;
  localparam int unsigned LN [NI] = '{1, 2, 4, 8, 16, 4};
  localparam bit          IE [NI] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  localparam logic [127:0] T1_IN  = 128'h00000000_00000000_00000000_00FF5300;
  localparam logic [127:0] T1_OUT = 128'h63636363_63636363_63636363_6316ED63;
  localparam logic [127:0] PT     = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] CT     = 128'hd42711aee0bf98f1b8b45de51e415230;

  logic         clk, rst, in_valid, in_inv, out_ready;
  logic [127:0] in_data;
  logic         ir [NI];
  logic         ov [NI];
  logic         bz [NI];
  logic [127:0] od [NI];

  int n_chk = 0;
  int n_fail = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sub_bytes_seq #(.LANES(LN[g]), .INV_EN(IE[g])) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(ir[g]), .in_data(in_data), .in_inv(in_inv),
      .out_valid(ov[g]), .out_ready(out_ready), .out_data(od[g]), .busy(bz[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, idx, $time, act, exp);
    end
  endtask

  // Reference S-boxes: inverse found by search, affine map in bit form
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'(9'h11b) << (k - 8));
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] b, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv ? isb[d[8*k +: 8]] : sb[d[8*k +: 8]];
    return r;
  endfunction

  // Protocol-level model: per instance, what the handshake must look like now
  typedef enum {M_IDLE, M_RUN, M_DONE} mph_t;
  mph_t         ph [NI];
  int           age [NI];
  logic [127:0] exp_q [NI];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        ph[i] = M_IDLE;
        chk("rst_ctl", i, 128'({ov[i], ir[i], bz[i]}), 128'(3'b010));
        chk("rst_data", i, od[i], 128'h0);
      end else begin
        if (ph[i] == M_IDLE) begin
          chk("idle_ctl", i, 128'({ov[i], ir[i], bz[i]}), 128'(3'b010));
          if (in_valid) begin
            ph[i]    = M_RUN;
            age[i]   = -1;
            exp_q[i] = ref_sub(in_data, in_inv & IE[i]);
          end
        end else if (ph[i] == M_RUN) begin
          age[i]++;
          if (age[i] < int'(16 / LN[i]))
            chk("run_ctl", i, 128'({ov[i], ir[i], bz[i]}), 128'(3'b001));
          else
            ph[i] = M_DONE;
        end
        if (ph[i] == M_DONE) begin
          chk("done_ctl", i, 128'({ov[i], ir[i], bz[i]}), 128'(3'b101));
          chk("done_data", i, od[i], exp_q[i]);
          if (out_ready) ph[i] = M_IDLE;
        end
      end
    end
  end

  task automatic wait_all(input bit want_valid, input string nm);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = 1'b1;
      for (int i = 0; i < NI; i++) if ((want_valid ? ov[i] : ir[i]) !== 1'b1) ok = 1'b0;
    end
    if (!ok) chk(nm, -1, 128'(0), 128'(1));
  endtask

  task automatic send(input logic [127:0] d, input logic inv);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_inv = inv;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic release_all();
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < NI; i++) chk("post_release", i, 128'({ov[i], ir[i], bz[i]}), 128'(3'b010));
  endtask

  // One block through every instance; fwd/inv are the required results
  task automatic run_block(input logic [127:0] d, input logic inv, input int hold,
                           input logic [127:0] fwd, input logic [127:0] invr);
    wait_all(1'b0, "timeout_idle");
    send(d, inv);
    wait_all(1'b1, "timeout_valid");
    repeat (hold) @(negedge clk);
    for (int i = 0; i < NI; i++) chk("result", i, od[i], (inv && IE[i]) ? invr : fwd);
    release_all();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < NI; i++) begin ph[i] = M_IDLE; age[i] = 0; exp_q[i] = '0; end
    build_tables();
    chk("model_t1", -1, ref_sub(T1_IN, 1'b0), T1_OUT);
    chk("model_fwd", -1, ref_sub(PT, 1'b0), CT);
    chk("model_inv", -1, ref_sub(CT, 1'b1), PT);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run_block(T1_IN, 1'b0, 0, T1_OUT, T1_OUT);
    run_block(PT, 1'b0, 0, CT, CT);
    run_block(CT, 1'b1, 0, ref_sub(CT, 1'b0), PT);
    run_block(PT, 1'b1, 10, ref_sub(PT, 1'b0), ref_sub(PT, 1'b1));
    run_block(CT, 1'b1, 0, ref_sub(CT, 1'b0), PT);

    // Inputs churn during RUN/DONE with in_valid held high
    wait_all(1'b0, "timeout_idle");
    send(PT, 1'b0);
    in_valid = 1'b1;
    begin
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 40 && !ok; n++) begin
        @(posedge clk); #1;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        in_inv  = 1'($urandom_range(0, 1));
        ok = 1'b1;
        for (int i = 0; i < NI; i++) if (ov[i] !== 1'b1) ok = 1'b0;
      end
      if (!ok) chk("timeout_iso", -1, 128'(0), 128'(1));
    end
    in_valid = 1'b0;
    for (int i = 0; i < NI; i++) chk("isolation", i, od[i], CT);
    release_all();

    // Reset after beat 7 of the LANES=1 instance
    wait_all(1'b0, "timeout_idle");
    send(PT, 1'b0);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("async_rst_ctl", i, 128'({ov[i], ir[i], bz[i]}), 128'(3'b010));
      chk("async_rst_data", i, od[i], 128'h0);
    end
    @(posedge clk); #1 rst = 1'b0;
    run_block(PT, 1'b0, 0, CT, CT);

    // Random traffic with random backpressure
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_inv    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    wait_all(1'b0, "timeout_drain");
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
